// File: rtl/collatz_result_capture.sv
// collatz_result_capture
// Watches the Collatz core (x, bs) and records each run's start value,
// step count (saturating) and peak value. When a run completes, it
// publishes one record on a valid/ready interface. An unaccepted record
// that gets overwritten raises a sticky lost flag.
// Optional feature macro: COLLATZ_TIMEOUT_EN. When it is defined, a run is
// aborted once it reaches MAX_STEPS steps: the record is flagged with
// res_to and no second record is produced for that run.
module collatz_result_capture #(
    parameter int XW        = 16,
    parameter int KW        = 20,
    parameter int MAX_STEPS = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] x,
    input  logic          bs,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [XW-1:0] res_start,
    output logic [KW-1:0] res_steps,
    output logic [XW-1:0] res_peak,
    output logic          res_lost,
    output logic          res_to,
    output logic          trk_busy
);

`ifdef COLLATZ_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, TRACK, PUBLISH, ABORT} state_t;
    localparam bit TO_EN = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, TRACK, PUBLISH} state_t;
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [KW-1:0] STEP_LIMIT = KW'(MAX_STEPS);

    // Saturating increment of the step counter
    function automatic logic [KW-1:0] sat_inc(input logic [KW-1:0] v);
        return (&v) ? v : v + KW'(1);
    endfunction

    // Unsigned maximum used for peak tracking
    function automatic logic [XW-1:0] umax(input logic [XW-1:0] a,
                                           input logic [XW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t        state;
    logic [XW-1:0] x_q;
    logic          bs_q;
    logic          armed;
    logic [XW-1:0] start_r;
    logic [KW-1:0] steps_r;
    logic [XW-1:0] peak_r;
    logic          step;
    logic [KW-1:0] steps_n;
    logic [XW-1:0] peak_n;
    logic          rise;
    logic          to_hit;
    logic          xfer;
`ifdef COLLATZ_TIMEOUT_EN
    logic          to_flag;
`endif

    // A step is any cycle where the core was busy and x moved
    assign step    = bs_q && (x != x_q);
    assign steps_n = step ? sat_inc(steps_r) : steps_r;
    assign peak_n  = step ? umax(peak_r, x) : peak_r;
    // armed blocks a run that was already in progress when reset released
    assign rise    = bs && !bs_q && armed;
    assign to_hit  = TO_EN && step && (steps_n == STEP_LIMIT);
    assign xfer    = res_valid && res_ready;

    // Input registers plus the arm flag that waits for bs to be seen low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            bs_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            x_q  <= x;
            bs_q <= bs;
            if (!bs) begin
                armed <= 1'b1;
            end
        end
    end

    // Run tracking FSM: capture start, count steps, follow the peak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            trk_busy <= 1'b0;
            start_r  <= '0;
            steps_r  <= '0;
            peak_r   <= '0;
`ifdef COLLATZ_TIMEOUT_EN
            to_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= TRACK;
                        trk_busy <= 1'b1;
                        start_r  <= x;
                        peak_r   <= x;
                        steps_r  <= '0;
`ifdef COLLATZ_TIMEOUT_EN
                        to_flag  <= 1'b0;
`endif
                    end
                end
                TRACK: begin
                    steps_r <= steps_n;
                    peak_r  <= peak_n;
                    if (!bs || to_hit) begin
                        state    <= PUBLISH;
                        trk_busy <= 1'b0;
`ifdef COLLATZ_TIMEOUT_EN
                        to_flag  <= to_hit;
`endif
                    end
                end
                PUBLISH: begin
`ifdef COLLATZ_TIMEOUT_EN
                    state <= to_flag ? ABORT : IDLE;
`else
                    state <= IDLE;
`endif
                end
`ifdef COLLATZ_TIMEOUT_EN
                ABORT: begin
                    // Let the aborted run drain without producing a record
                    if (!bs) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Result record: load on PUBLISH, clear valid and lost on transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_start <= '0;
            res_steps <= '0;
            res_peak  <= '0;
            res_lost  <= 1'b0;
`ifdef COLLATZ_TIMEOUT_EN
            res_to    <= 1'b0;
`endif
        end else if (state == PUBLISH) begin
            res_valid <= 1'b1;
            res_start <= start_r;
            res_steps <= steps_r;
            res_peak  <= peak_r;
            // Overwriting an untransferred record marks it lost (sticky)
            res_lost  <= res_valid && !res_ready;
`ifdef COLLATZ_TIMEOUT_EN
            res_to    <= to_flag;
`endif
        end else if (xfer) begin
            res_valid <= 1'b0;
            res_lost  <= 1'b0;
        end
    end

`ifndef COLLATZ_TIMEOUT_EN
    assign res_to = 1'b0;
`endif

endmodule

// File: tb/tb_collatz_result_capture.sv
// Directed bench for collatz_result_capture. The core is modelled by
// driving x/bs one Collatz value per clock. A second instance with a
// narrow step counter exercises counter saturation in few cycles.
module tb_collatz_result_capture;

    logic        clk;
    logic        rst_n;
    logic [15:0] x;
    logic        bs;
    logic        res_ready;
    logic        res_valid;
    logic [15:0] res_start;
    logic [19:0] res_steps;
    logic [15:0] res_peak;
    logic        res_lost;
    logic        res_to;
    logic        trk_busy;

    logic        s_valid;
    logic [15:0] s_start;
    logic [5:0]  s_steps;
    logic [15:0] s_peak;
    logic        s_lost;
    logic        s_to;
    logic        s_busy;

    int n_vec;
    int n_err;
    int xfer_cnt;

    collatz_result_capture #(.XW(16), .KW(20), .MAX_STEPS(50)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .bs(bs), .res_ready(res_ready),
        .res_valid(res_valid), .res_start(res_start), .res_steps(res_steps),
        .res_peak(res_peak), .res_lost(res_lost), .res_to(res_to),
        .trk_busy(trk_busy)
    );

    collatz_result_capture #(.XW(16), .KW(6), .MAX_STEPS(1000)) dut_s (
        .clk(clk), .rst_n(rst_n), .x(x), .bs(bs), .res_ready(res_ready),
        .res_valid(s_valid), .res_start(s_start), .res_steps(s_steps),
        .res_peak(s_peak), .res_lost(s_lost), .res_to(s_to),
        .trk_busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted records on the main instance
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            xfer_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nxt(input int v);
        return (v % 2 == 0) ? v / 2 : 3 * v + 1;
    endfunction

    // Drive one full core run; returns one edge after bs=0 was sampled
    task automatic run_core(input int co, input bit chk_busy);
        int v;
        v  = co;
        x  = 16'(v);
        bs = 1'b1;
        tick();
        if (chk_busy) check_val("busy_run", trk_busy, 1);
        while (v != 1) begin
            v = nxt(v);
            x = 16'(v);
            tick();
        end
        bs = 1'b0;
        tick();
    endtask

    initial begin
        int c0;
        int v;
        n_vec = 0; n_err = 0; xfer_cnt = 0;
        x = '0; bs = 1'b0; res_ready = 1'b1; rst_n = 1'b0;
        tick(); tick();
        check_val("rst_valid", res_valid, 0);
        check_val("rst_start", res_start, 0);
        check_val("rst_steps", res_steps, 0);
        check_val("rst_peak",  res_peak, 0);
        check_val("rst_lost",  res_lost, 0);
        check_val("rst_to",    res_to, 0);
        check_val("rst_busy",  trk_busy, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Run of 6 with ready high
        run_core(6, 1'b1);
        check_val("t1_lat", res_valid, 0);
        check_val("t1_busy", trk_busy, 0);
        tick();
        check_val("t1_valid", res_valid, 1);
        check_val("t1_start", res_start, 6);
        check_val("t1_steps", res_steps, 8);
        check_val("t1_peak", res_peak, 16);
        check_val("t1_lost", res_lost, 0);
        check_val("t1_to", res_to, 0);

        // Run of 27, valid lasts one cycle
        run_core(27, 1'b0);
        tick();
        check_val("t2_valid", res_valid, 1);
        check_val("t2_start", res_start, 27);
        check_val("t2_steps", res_steps, 111);
        check_val("t2_peak", res_peak, 9232);
        check_val("t2_to", res_to, 0);
        tick();
        check_val("t2_pulse", res_valid, 0);

        // Overwrite with ready low
        res_ready = 1'b0;
        tick();
        run_core(6, 1'b0);
        tick();
        check_val("t3_v1", res_valid, 1);
        check_val("t3_lost1", res_lost, 0);
        run_core(7, 1'b0);
        tick();
        check_val("t3_valid", res_valid, 1);
        check_val("t3_start", res_start, 7);
        check_val("t3_steps", res_steps, 16);
        check_val("t3_peak", res_peak, 52);
        check_val("t3_lost", res_lost, 1);
        tick();
        check_val("t3_hold", res_start, 7);
        res_ready = 1'b1;
        tick();
        check_val("t3_clr_v", res_valid, 0);
        check_val("t3_clr_l", res_lost, 0);

        // Reset in the middle of a run of 27
        tick();
        c0 = xfer_cnt;
        v  = 27;
        x  = 16'(v);
        bs = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            v = nxt(v);
            x = 16'(v);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_val("t4_busy", trk_busy, 0);
        check_val("t4_steps", res_steps, 0);
        check_val("t4_start", res_start, 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        v = nxt(v);
        x = 16'(v);
        tick();
        check_val("t4_ign", trk_busy, 0);
        while (v != 1) begin
            v = nxt(v);
            x = 16'(v);
            tick();
        end
        bs = 1'b0;
        tick(); tick(); tick();
        check_val("t4_norec", res_valid, 0);
        check_val("t4_noxfer", xfer_cnt - c0, 0);
        run_core(3, 1'b1);
        tick();
        check_val("t4_valid", res_valid, 1);
        check_val("t4_start", res_start, 3);
        check_val("t4_steps", res_steps, 7);
        check_val("t4_peak", res_peak, 16);
        tick();

`ifdef COLLATZ_TIMEOUT_EN
        // Step limit of 50 on the run of 27
        c0 = xfer_cnt;
        run_core(27, 1'b0);
        tick(); tick(); tick();
        check_val("t5_recs", xfer_cnt - c0, 1);
        check_val("t5_start", res_start, 27);
        check_val("t5_steps", res_steps, 50);
        check_val("t5_peak", res_peak, 1780);
        check_val("t5_to", res_to, 1);
        c0 = xfer_cnt;
        run_core(6, 1'b0);
        tick();
        check_val("t5n_valid", res_valid, 1);
        check_val("t5n_steps", res_steps, 8);
        check_val("t5n_to", res_to, 0);
        tick(); tick();
        check_val("t5n_recs", xfer_cnt - c0, 1);
`endif

        // Single-cycle bs pulse with constant x
        x  = 16'd5;
        bs = 1'b1;
        tick();
        bs = 1'b0;
        tick(); tick();
        check_val("t6_valid", res_valid, 1);
        check_val("t6_start", res_start, 5);
        check_val("t6_steps", res_steps, 0);
        check_val("t6_peak", res_peak, 5);
        tick(); tick();

        // 2^6+3 toggles: narrow counter saturates at 63
        x  = 16'd5;
        bs = 1'b1;
        tick();
        for (int i = 0; i < 67; i++) begin
            x = (x == 16'd5) ? 16'd4 : 16'd5;
            tick();
        end
        bs = 1'b0;
        tick(); tick();
        check_val("t6_wide", res_steps, 67);
        check_val("t6s_valid", s_valid, 1);
        check_val("t6s_sat", s_steps, 63);
        check_val("t6s_peak", s_peak, 5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
